seq_gen: RTL and testbench
==========================

Name: seq_gen

Overview:
- Serial bit-pattern transmitter, MSB-first, one bit per clk. It is the transmit-side counterpart of the team's Moore serial sequence detectors.
- A parallel pattern of programmable length is loaded on a start pulse and shifted out on dout with a valid qualifier.
- The pattern can repeat a programmable number of times, with a fixed idle gap between repetitions.
- Used to drive test sequences into detector blocks and as a generic serial framer.

Parameters:
- WIDTH, 16, max pattern length in bits.
- CNT_W, 4, width of len and of the bit index; must satisfy 2^CNT_W >= WIDTH.
- IDLE_LVL, 1'b1, level driven on dout whenever dvalid=0.
- GAP, 2, idle cycles between repetitions; 0 means back-to-back.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, reset.
- start, input, 1, request to transmit; sampled only in IDLE.
- pattern, input, WIDTH, bits to send; bit len is sent first, bit 0 last.
- len, input, CNT_W, number of bits per repetition minus 1 (0..WIDTH-1).
- reps, input, 4, number of repetitions minus 1 (0..15).
- dout, output, 1, serial data.
- dvalid, output, 1, high while dout carries a pattern bit.
- busy, output, 1, high from the cycle after start acceptance through the DONE cycle.
- done, output, 1, one-cycle pulse at completion.

Behaviour:
- Reset: rst is asynchronous, active-high; clk is the clock. While rst=1: state=IDLE, dout=IDLE_LVL, dvalid=0, busy=0, done=0, all internal counters 0.
- Outputs: all registered, no combinational path from inputs to outputs.
- States: IDLE, SEND, GAP, DONE, one-hot encoded; any illegal encoding returns to IDLE.
- IDLE:
  - Outputs at idle values.
  - start=1 at edge N: capture pattern, len and reps into shadow registers; bit_idx<=len; rep_cnt<=reps; go to SEND.
- SEND:
  - From edge N+1, dout=shadow[bit_idx], dvalid=1, busy=1.
  - Each edge: bit_idx decrements.
  - When bit_idx=0 and rep_cnt=0: go to DONE.
  - When bit_idx=0 and rep_cnt>0: rep_cnt decrements, bit_idx<=len, then go to GAP if GAP>0, otherwise stay in SEND.
- GAP:
  - dout=IDLE_LVL, dvalid=0, busy=1.
  - Lasts exactly GAP cycles (gap counter), then returns to SEND.
- DONE:
  - One cycle: done=1, busy=1, dvalid=0, dout=IDLE_LVL.
  - Then IDLE. busy and done fall together.
- Latency and timing:
  - First bit valid one cycle after start is sampled.
  - Total busy cycles = (len+1)(reps+1) + GAP*reps + 1.
  - Earliest next start is accepted on the first IDLE edge after DONE.
- Boundary conditions:
  - start while not IDLE: ignored, not queued.
  - Changes to pattern, len or reps after acceptance: no effect on the transmission in progress.
  - len=0: single-bit repetitions.
  - len=WIDTH-1: full-width pattern.
  - Bits of pattern above len: never transmitted.
  - Reset mid-operation: immediate return to reset values; a partially sent pattern is abandoned, done is not pulsed, and the next start behaves normally.

Optional Feature:
- Macro: SEQ_GEN_PARITY_EN.
- When defined:
  - After bit 0 of every repetition, one extra SEND cycle transmits the even-parity bit (XOR of the len+1 transmitted bits), with dvalid=1.
  - Per-repetition length becomes len+2 bits.
  - Busy-cycle formula uses (len+2) in place of (len+1).
  - The gap, if any, follows the parity bit.
- When undefined: no parity logic, no extra cycle.

Test Plan:
- Reset: assert rst asynchronously mid-clock -> dout=1, dvalid=0, busy=0, done=0 immediately; start held high during reset is ignored.
- Single pattern: pattern=16'h0035, len=6, reps=0, start pulse at edge N -> dout=0,1,1,0,1,0,1 with dvalid=1 on cycles N+1..N+7; done=1 at N+8 only; busy high N+1..N+8. With SEQ_GEN_PARITY_EN, an extra bit 0 (four ones) at N+8 and done at N+9.
- Repeats with gap: pattern=16'h0035, len=6, reps=2, GAP=2 -> three 7-bit bursts separated by 2 cycles of dout=1/dvalid=0; done at 26 cycles after start (25 busy cycles before it).
- Length extremes: len=0 with pattern bit0=0 -> single cycle dout=0, done next cycle. len=15 with pattern=16'hA5C3 -> dout bit sequence 1010_0101_1100_0011.
- Busy protection: second start and a pattern change to 16'hFFFF mid-transmission -> original bits continue unchanged, no second transmission, busy stays continuous.
- Reset mid-send: assert rst after 3 bits of 16'h0035/len=6 -> outputs return to idle values with no done pulse; a fresh start afterwards transmits the full 7 bits correctly.

Source files
------------

// File: rtl/seq_gen.sv
// seq_gen: MSB-first serial pattern transmitter with programmable length,
// repetition count and a fixed idle gap between repetitions.
// Optional feature: define SEQ_GEN_PARITY_EN to append an even-parity bit
// after bit 0 of every repetition.
//
// Timing model: the FSM state and counters advance on each edge, and every
// output is a register loaded from the *current* state. Outputs therefore
// trail the state by exactly one cycle. A start accepted at edge N shows its
// first bit after edge N+1.

module seq_gen #(
    parameter int   WIDTH    = 16,   // max pattern length in bits
    parameter int   CNT_W    = 4,    // width of len / bit index, 2**CNT_W >= WIDTH
    parameter logic IDLE_LVL = 1'b1, // dout level whenever dvalid is low
    parameter int   GAP      = 2     // idle cycles between repetitions
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] len,
    input  logic [3:0]       reps,
    output logic             dout,
    output logic             dvalid,
    output logic             busy,
    output logic             done
);

    // Gap counter counts GAP-1 down to 0; keep at least one bit so that a
    // GAP of 0 or 1 still yields a legal vector.
    localparam int GAP_W = (GAP > 2) ? $clog2(GAP) : 1;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_SEND = 4'b0010,
        ST_GAP  = 4'b0100,
        ST_DONE = 4'b1000
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] shadow_q,  shadow_d;
    logic [CNT_W-1:0] len_q,     len_d;
    logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
    logic [3:0]       rep_q,     rep_d;
    logic [GAP_W-1:0] gap_q,     gap_d;

    logic dout_d, dvalid_d, busy_d, done_d;
    logic end_of_rep;

`ifdef SEQ_GEN_PARITY_EN
    logic par_acc_q,   par_acc_d;    // running XOR of bits sent this repetition
    logic par_phase_q, par_phase_d;  // next SEND cycle carries the parity bit
`endif

    // Next-state, next-counter and next-output logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case statement leaves one unassigned, which would infer a latch.
        state_d    = state_q;
        shadow_d   = shadow_q;
        len_d      = len_q;
        bit_idx_d  = bit_idx_q;
        rep_d      = rep_q;
        gap_d      = gap_q;
        dout_d     = IDLE_LVL;
        dvalid_d   = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        end_of_rep = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
        par_acc_d   = par_acc_q;
        par_phase_d = par_phase_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Freeze the request so later input changes cannot
                // disturb the transmission.
                if (start) begin
                    shadow_d  = pattern;
                    len_d     = len;
                    bit_idx_d = len;
                    rep_d     = reps;
                    gap_d     = '0;
                    state_d   = ST_SEND;
`ifdef SEQ_GEN_PARITY_EN
                    par_acc_d   = 1'b0;
                    par_phase_d = 1'b0;
`endif
                end
            end

            ST_SEND: begin
                busy_d   = 1'b1;
                dvalid_d = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
                if (par_phase_q) begin
                    // Extra cycle: send the even-parity bit, then wrap up
                    // the repetition exactly as bit 0 would without parity.
                    dout_d      = par_acc_q;
                    par_acc_d   = 1'b0;
                    par_phase_d = 1'b0;
                    end_of_rep  = 1'b1;
                end else begin
                    dout_d    = shadow_q[bit_idx_q];
                    par_acc_d = par_acc_q ^ shadow_q[bit_idx_q];
                    if (bit_idx_q == '0) begin
                        par_phase_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q - 1'b1;
                    end
                end
`else
                dout_d = shadow_q[bit_idx_q];
                if (bit_idx_q == '0) begin
                    end_of_rep = 1'b1;
                end else begin
                    bit_idx_d = bit_idx_q - 1'b1;
                end
`endif
                if (end_of_rep) begin
                    if (rep_q == 4'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        rep_d     = rep_q - 4'd1;
                        bit_idx_d = len_q;
                        if (GAP > 0) begin
                            gap_d   = GAP_W'(GAP - 1);
                            state_d = ST_GAP;
                        end
                    end
                end
            end

            ST_GAP: begin
                // Idle line, still busy; hold for exactly GAP cycles.
                busy_d = 1'b1;
                if (gap_q == '0) begin
                    state_d = ST_SEND;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end

            ST_DONE: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                // Any non-one-hot encoding recovers to IDLE with idle outputs.
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, shadow and output registers with async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: shadow data is reset too; it is a small register, not a
            // memory array, and a clean value keeps reset behaviour fully
            // deterministic.
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            len_q     <= '0;
            bit_idx_q <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            dout      <= IDLE_LVL;
            dvalid    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            len_q     <= len_d;
            bit_idx_q <= bit_idx_d;
            rep_q     <= rep_d;
            gap_q     <= gap_d;
            dout      <= dout_d;
            dvalid    <= dvalid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

`ifdef SEQ_GEN_PARITY_EN
    // Parity accumulator and parity-cycle flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_acc_q   <= 1'b0;
            par_phase_q <= 1'b0;
        end else begin
            par_acc_q   <= par_acc_d;
            par_phase_q <= par_phase_d;
        end
    end
`endif

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: self-checking bench for seq_gen. A transaction-level model
// expands each accepted request into the per-cycle output sequence it must
// produce and compares the DUT against it every cycle. Honours
// SEQ_GEN_PARITY_EN when defined.

module tb_seq_gen;

    localparam int   WIDTH    = 16;
    localparam int   CNT_W    = 4;
    localparam int   GAP      = 2;
    localparam logic IDLE_LVL = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    // Output tuple {dout, dvalid, busy, done}
    localparam logic [3:0] IDLE_V = {IDLE_LVL, 3'b000};
    localparam logic [3:0] GAP_V  = {IDLE_LVL, 3'b010};
    localparam logic [3:0] DONE_V = {IDLE_LVL, 3'b011};

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] pattern = '0;
    logic [CNT_W-1:0] len = '0;
    logic [3:0]       reps = '0;
    logic             dout, dvalid, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_q[$];
    logic [3:0] exp_out   = IDLE_V;
    int         busy_run  = 0;
    int         exp_busy  = 0;

    seq_gen #(
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W),
        .IDLE_LVL(IDLE_LVL),
        .GAP     (GAP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .pattern(pattern),
        .len    (len),
        .reps   (reps),
        .dout   (dout),
        .dvalid (dvalid),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, want);
        end
    endtask

    // Expand one accepted request into its expected cycle-by-cycle outputs.
    task automatic push_txn(input logic [WIDTH-1:0] p, input int l, input int r);
        logic par;
        for (int k = 0; k <= r; k++) begin
            par = 1'b0;
            for (int i = l; i >= 0; i--) begin
                exp_q.push_back({p[i], 3'b110});
                par ^= p[i];
            end
            if (PAR != 0) exp_q.push_back({par, 3'b110});
            if (k < r) begin
                for (int g = 0; g < GAP; g++) exp_q.push_back(GAP_V);
            end
        end
        exp_q.push_back(DONE_V);
        exp_busy = (l + 1 + PAR) * (r + 1) + GAP * r + 1;
    endtask

    // One clock: update the model at the edge, compare at the falling edge.
    task automatic tick();
        logic was_empty;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_out  = IDLE_V;
            busy_run = 0;
        end else begin
            was_empty = (exp_q.size() == 0);
            exp_out   = was_empty ? IDLE_V : exp_q.pop_front();
            if (start && was_empty) push_txn(pattern, int'(len), int'(reps));
        end
        @(negedge clk);
        check("outs", int'({dout, dvalid, busy, done}), int'(exp_out));
        if (busy) busy_run++;
        if (done) begin
            check("busy_len", busy_run, exp_busy);
            busy_run = 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [WIDTH-1:0] p, input logic [CNT_W-1:0] l,
                        input logic [3:0] r);
        pattern = p;
        len     = l;
        reps    = r;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Assert reset between edges and expect idle outputs immediately.
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1 check("rst_async", int'({dout, dvalid, busy, done}), int'(IDLE_V));
        exp_q.delete();
        exp_out  = IDLE_V;
        busy_run = 0;
        tick();
        tick();
        rst   = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        // Reset with start held high: must be ignored.
        #1;
        rst   = 1'b1;
        start = 1'b1;
        pattern = 16'h0035;
        len   = 4'd6;
        run(3);
        rst   = 1'b0;
        start = 1'b0;
        run(2);

        // Single 7-bit pattern.
        send(16'h0035, 4'd6, 4'd0);
        run(12);

        // Three repetitions with gaps.
        send(16'h0035, 4'd6, 4'd2);
        run(30);

        // Shortest and longest patterns.
        send(16'hFFFE, 4'd0, 4'd0);
        run(4);
        send(16'hA5C3, 4'd15, 4'd0);
        run(20);

        // Busy protection: new start and pattern change mid-transmission.
        send(16'h0035, 4'd6, 4'd1);
        run(4);
        pattern = 16'hFFFF;
        len     = 4'd15;
        reps    = 4'd3;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        run(20);

        // Reset after three bits, then a clean restart.
        send(16'h0035, 4'd6, 4'd0);
        run(3);
        mid_reset();
        run(3);
        send(16'h0035, 4'd6, 4'd0);
        run(12);

        // Randomised traffic with occasional mid-clock resets.
        for (int c = 0; c < 4000; c++) begin
            start   = ($urandom_range(0, 5) == 0);
            pattern = WIDTH'($urandom);
            len     = CNT_W'($urandom_range(0, WIDTH - 1));
            reps    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(0, 2));
            tick();
            if ($urandom_range(0, 399) == 0) mid_reset();
        end
        start = 1'b0;
        run(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
